// File: rtl/uart_tx_if.sv
// FIFO-side and line-side signals of the UART transmitter, bundled so the
// transmitter and whatever drives it agree on direction through modports.
interface uart_tx_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  en;
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_data;
  logic                  fifo_rd;
  logic                  tx;
  logic                  busy;
  logic                  done;

  // System side: owns the enable and the FIFO read port, watches the line.
  modport master (
    output en, fifo_empty, fifo_data,
    input  fifo_rd, tx, busy, done
  );

  // Transmitter side.
  modport slave (
    input  en, fifo_empty, fifo_data,
    output fifo_rd, tx, busy, done
  );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter. Pops one byte at a time from a synchronous FIFO whose
// DATAo is registered (valid the cycle after the read strobe) and sends it
// LSB first as start / data / optional parity / stop bits. Every output is
// a register; the line idles high.
module uart_tx #(
  parameter int CLK_FREQ   = 16_000_000,
  parameter int BAUD_RATE  = 1_000_000,
  parameter int DATA_WIDTH = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic     clk,
  input  logic     rst_n,
  uart_tx_if.slave bus
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int STOP_CLKS    = STOP_BITS * CLKS_PER_BIT;
  // The baud counter is shared by every bit, including the (possibly
  // double-length) stop period, so it is sized for the longest of them.
  localparam int BAUD_W       = $clog2(STOP_CLKS);
  localparam int BIT_W        = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [BAUD_W-1:0] BIT_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] STOP_LAST = BAUD_W'(STOP_CLKS - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_WIDTH - 1);
  localparam logic              ODD       = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    IDLE, FETCH, LOAD, START, DATA, PARITY, STOP
  } state_t;

  state_t                state, state_nx;
  logic [BAUD_W-1:0]     baud_cnt, baud_cnt_nx;
  logic [BIT_W-1:0]      bit_cnt, bit_cnt_nx;
  logic [DATA_WIDTH-1:0] shreg, shreg_nx;
  logic                  par_bit, par_bit_nx;
  logic                  tx_line, tx_line_nx;
  logic                  rd_pulse, rd_pulse_nx;
  logic                  busy_flag, busy_flag_nx;
  logic                  done_pulse, done_pulse_nx;
  logic                  bit_end;

  assign bit_end     = (baud_cnt == BIT_LAST);
  assign bus.tx      = tx_line;
  assign bus.fifo_rd = rd_pulse;
  assign bus.busy    = busy_flag;
  assign bus.done    = done_pulse;

  // Next-state and next-output decode; every register holds unless a state
  // says otherwise, and the two strobes default low so they last one cycle.
  always_comb begin
    state_nx      = state;
    baud_cnt_nx   = baud_cnt;
    bit_cnt_nx    = bit_cnt;
    shreg_nx      = shreg;
    par_bit_nx    = par_bit;
    tx_line_nx    = tx_line;
    rd_pulse_nx   = 1'b0;
    busy_flag_nx  = busy_flag;
    done_pulse_nx = 1'b0;
    unique case (state)
      IDLE: begin
        // Enable and FIFO status only matter here: a frame once started runs
        // to completion regardless of either.
        if (bus.en && !bus.fifo_empty) begin
          rd_pulse_nx  = 1'b1;
          busy_flag_nx = 1'b1;
          state_nx     = FETCH;
        end
      end
      FETCH: begin
        // The FIFO captures its output on this edge; nothing to sample yet.
        state_nx = LOAD;
      end
      LOAD: begin
        shreg_nx    = bus.fifo_data;
        par_bit_nx  = (^bus.fifo_data) ^ ODD;
        tx_line_nx  = 1'b0;
        baud_cnt_nx = '0;
        bit_cnt_nx  = '0;
        state_nx    = START;
      end
      START: begin
        if (bit_end) begin
          tx_line_nx  = shreg[0];
          shreg_nx    = shreg >> 1;
          baud_cnt_nx = '0;
          state_nx    = DATA;
        end else begin
          baud_cnt_nx = baud_cnt + 1'b1;
        end
      end
      DATA: begin
        if (bit_end) begin
          baud_cnt_nx = '0;
          if (bit_cnt == DATA_LAST) begin
            if (PARITY_EN != 0) begin
              tx_line_nx = par_bit;
              state_nx   = PARITY;
            end else begin
              tx_line_nx = 1'b1;
              state_nx   = STOP;
            end
          end else begin
            bit_cnt_nx = bit_cnt + 1'b1;
            tx_line_nx = shreg[0];
            shreg_nx   = shreg >> 1;
          end
        end else begin
          baud_cnt_nx = baud_cnt + 1'b1;
        end
      end
      PARITY: begin
        if (bit_end) begin
          tx_line_nx  = 1'b1;
          baud_cnt_nx = '0;
          state_nx    = STOP;
        end else begin
          baud_cnt_nx = baud_cnt + 1'b1;
        end
      end
      STOP: begin
        // One or two bit periods of mark, counted in a single run.
        if (baud_cnt == STOP_LAST) begin
          baud_cnt_nx   = '0;
          busy_flag_nx  = 1'b0;
          done_pulse_nx = 1'b1;
          state_nx      = IDLE;
        end else begin
          baud_cnt_nx = baud_cnt + 1'b1;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Control state and registered outputs; reset abandons any frame in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      tx_line    <= 1'b1;
      rd_pulse   <= 1'b0;
      busy_flag  <= 1'b0;
      done_pulse <= 1'b0;
    end else begin
      state      <= state_nx;
      baud_cnt   <= baud_cnt_nx;
      bit_cnt    <= bit_cnt_nx;
      tx_line    <= tx_line_nx;
      rd_pulse   <= rd_pulse_nx;
      busy_flag  <= busy_flag_nx;
      done_pulse <= done_pulse_nx;
    end
  end

  // Shift register and parity are reloaded in LOAD before use, so no reset.
  always_ff @(posedge clk) begin
    shreg   <= shreg_nx;
    par_bit <= par_bit_nx;
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: three transmitters (8N1; even parity with two stop
// bits; odd parity with one stop bit) share clock, reset and enable and are
// fed the same byte stream through their own FIFO models. Bytes are pushed
// into a shared scoreboard when issued; a monitor predicts, from the frame
// rules alone, the line level, busy, done and read strobe of every
// transmitter every cycle and compares them with what the DUTs present.
module tb_uart_tx;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b1;
  logic [7:0] mem [256];
  int         wr_cnt = 0;

  logic [2:0] tx_v, busy_v, done_v, rd_v, empty_v;

  int  n_checks = 0;
  int  n_fail = 0;
  bit  final_req = 1'b0;
  bit  final_done = 1'b0;

  // Reference-model state, one entry per configuration.
  logic       m_busy [3] = '{1'b0, 1'b0, 1'b0};
  int         m_t [3] = '{0, 0, 0};
  int         m_idx [3] = '{0, 0, 0};
  logic [7:0] m_byte [3] = '{8'h00, 8'h00, 8'h00};
  logic       p_avail [3] = '{1'b0, 1'b0, 1'b0};
  int         dut_frames [3] = '{0, 0, 0};
  logic       p_rstn = 1'b0;
  logic       p_en = 1'b0;
  logic       e_rd, e_done, e_tx;
  logic [3:0] got, want;

  always #5 clk = ~clk;

  function automatic logic pe(int cfg);
    return (cfg != 0);
  endfunction

  function automatic logic odd(int cfg);
    return (cfg == 2);
  endfunction

  function automatic int flen(int cfg);
    return (1 + 8 + (pe(cfg) ? 1 : 0) + ((cfg == 1) ? 2 : 1)) * CPB;
  endfunction

  // Level of bit slot k of the frame carrying byte b.
  function automatic logic frame_bit(int cfg, logic [7:0] b, int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    if (pe(cfg) && k == 9) return (^b) ^ odd(cfg);
    return 1'b1;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_cfg
    localparam int PE  = (g == 0) ? 0 : 1;
    localparam int ODD = (g == 2) ? 1 : 0;
    localparam int SB  = (g == 1) ? 2 : 1;

    uart_tx_if #(.DATA_WIDTH(8)) bus ();
    int         rd_ptr = 0;
    logic [7:0] fdata = 8'h00;

    assign bus.en         = en;
    assign bus.fifo_empty = (rd_ptr >= wr_cnt);
    assign bus.fifo_data  = fdata;
    assign tx_v[g]        = bus.tx;
    assign busy_v[g]      = bus.busy;
    assign done_v[g]      = bus.done;
    assign rd_v[g]        = bus.fifo_rd;
    assign empty_v[g]     = bus.fifo_empty;

    // Synchronous FIFO with registered read data.
    always @(posedge clk) begin
      if (bus.fifo_rd && rd_ptr < wr_cnt) begin
        fdata  <= mem[rd_ptr];
        rd_ptr <= rd_ptr + 1;
      end
    end

    uart_tx #(
      .CLK_FREQ  (16_000_000),
      .BAUD_RATE (1_000_000),
      .DATA_WIDTH(8),
      .PARITY_EN (PE),
      .PARITY_ODD(ODD),
      .STOP_BITS (SB)
    ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
    );
  end

  // Monitor: advance the model by one clock edge, then compare.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      e_rd   = 1'b0;
      e_done = 1'b0;
      if (!p_rstn) begin
        m_busy[i] = 1'b0;
      end else if (m_busy[i]) begin
        m_t[i] = m_t[i] + 1;
        if (m_t[i] == flen(i)) begin
          m_busy[i] = 1'b0;
          e_done    = 1'b1;
        end
      end else if (p_en && p_avail[i]) begin
        e_rd      = 1'b1;
        m_busy[i] = 1'b1;
        m_t[i]    = -2;
        m_byte[i] = mem[m_idx[i]];
        m_idx[i]  = m_idx[i] + 1;
      end
      e_tx = (m_busy[i] && m_t[i] >= 0) ? frame_bit(i, m_byte[i], m_t[i] / CPB) : 1'b1;
      want = {e_tx, m_busy[i], e_done, e_rd};
      got  = {tx_v[i], busy_v[i], done_v[i], rd_v[i]};
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL cfg%0d outputs at %0t: tx/busy/done/rd got %b required %b",
                 i, $time, got, want);
      end
      if (done_v[i] === 1'b1) dut_frames[i]++;
      p_avail[i] = (m_idx[i] < wr_cnt);
    end
    p_rstn = rst_n;
    p_en   = en;
    if (final_req && !final_done) begin
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (empty_v[i] !== 1'b1) begin
          n_fail++;
          $display("FAIL cfg%0d fifo_drained: empty got %b required 1", i, empty_v[i]);
        end
        n_checks++;
        if (dut_frames[i] != wr_cnt - 1) begin
          n_fail++;
          $display("FAIL cfg%0d frame_count: got %0d required %0d", i, dut_frames[i], wr_cnt - 1);
        end
      end
      final_done = 1'b1;
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    mem[wr_cnt] = b;
    wr_cnt      = wr_cnt + 1;
  endtask

  initial begin
    int n;
    // Reset held with a byte already waiting; released after four edges.
    push(8'hA5);
    cycles(4);
    rst_n = 1'b1;
    cycles(230);
    // Parity byte (odd number of ones).
    push(8'h07);
    cycles(230);
    // Back-to-back frames.
    push(8'h55);
    push(8'h0F);
    push(8'hFF);
    cycles(650);
    // Enable dropped during data bit 3 of the first of two queued frames.
    push(8'h3C);
    push(8'hC3);
    cycles(72);
    en = 1'b0;
    cycles(300);
    en = 1'b1;
    cycles(230);
    // Reset during data bit 5; that byte is lost, the next one goes out.
    push(8'h96);
    push(8'h69);
    cycles(104);
    rst_n = 1'b0;
    cycles(2);
    rst_n = 1'b1;
    cycles(230);
    // Random bytes, bursts and enable gaps.
    for (int it = 0; it < 8; it++) begin
      n = $urandom_range(1, 3);
      for (int k = 0; k < n; k++) push(8'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        en = 1'b0;
        cycles($urandom_range(1, 300));
        en = 1'b1;
      end else begin
        cycles($urandom_range(0, 400));
      end
    end
    en = 1'b1;
    cycles(5000);
    final_req = 1'b1;
    for (int k = 0; k < 10 && !final_done; k++) @(posedge clk);
    if (!final_done) begin
      $display("FAIL final_check: monitor did not respond within 10 cycles");
      $fatal(1);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
